// File: rtl/fpu_fp64_to_fp32_if.sv
// Handshake bundle for the binary64 -> binary32 narrowing converter.
// The master drives operands and consumes results; the slave is the converter.
interface fpu_fp64_to_fp32_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] src;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dst;
  logic        flg_ovf;
  logic        flg_unf;
  logic        flg_inx;

  modport master (
    output in_valid, src, out_ready,
    input  in_ready, out_valid, dst, flg_ovf, flg_unf, flg_inx
  );

  modport slave (
    input  in_valid, src, out_ready,
    output in_ready, out_valid, dst, flg_ovf, flg_unf, flg_inx
  );
endinterface

// File: rtl/fpu_fp64_to_fp32.sv
// Two-stage binary64 -> binary32 narrowing converter (classify, then round/pack).
// Define FPU_F64TO32_DENORM_EN for gradual underflow; otherwise tiny results flush to zero.
module fpu_fp64_to_fp32 (
  input  logic                     clk,
  input  logic                     reset,
  fpu_fp64_to_fp32_if.slave        bus
);

  typedef enum logic [1:0] {CLS_ZERO, CLS_INF, CLS_NAN, CLS_FIN} cls_t;

  logic              adv1, adv2;

  logic [10:0]       in_e;
  logic [51:0]       in_f;
  cls_t              in_cls;
  logic signed [11:0] in_eb;

  logic              s1_valid;
  logic              s1_sign;
  cls_t              s1_cls;
  logic signed [11:0] s1_eb;
  logic [22:0]       s1_m;
  logic              s1_g;
  logic              s1_sticky;

  logic              s2_valid;
  logic [31:0]       s2_dst;
  logic              s2_ovf, s2_unf, s2_inx;

  logic [31:0]       nx_dst;
  logic              nx_ovf, nx_unf, nx_inx;
  logic              inc;
  logic [23:0]       mr;
  logic [8:0]        exp9;

`ifdef FPU_F64TO32_DENORM_EN
  logic [11:0]       sh;
  logic [49:0]       wide;
  logic [23:0]       dm;
  logic              dg, ds, dinc;
  logic [23:0]       dr;
`endif

  assign adv2         = !s2_valid || bus.out_ready;
  assign adv1         = !s1_valid || adv2;
  assign bus.in_ready = adv1;

  assign in_e  = bus.src[62:52];
  assign in_f  = bus.src[51:0];
  assign in_eb = $signed({1'b0, in_e}) - 12'sd896;

  // A zero exponent covers double denormals too: they are far below binary32 range.
  always_comb begin
    in_cls = CLS_FIN;
    if (in_e == 11'd0)
      in_cls = CLS_ZERO;
    else if (in_e == 11'h7FF)
      in_cls = (in_f == 52'd0) ? CLS_INF : CLS_NAN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (adv1) begin
      s1_valid  <= bus.in_valid;
      s1_sign   <= bus.src[63];
      s1_cls    <= in_cls;
      s1_eb     <= in_eb;
      s1_m      <= in_f[51:29];
      s1_g      <= in_f[28];
      s1_sticky <= |in_f[27:0];
    end
  end

  assign inc  = s1_g && (s1_sticky || s1_m[0]);
  assign mr   = {1'b0, s1_m} + {23'd0, inc};
  assign exp9 = {1'b0, s1_eb[7:0]} + {8'd0, mr[23]};

`ifdef FPU_F64TO32_DENORM_EN
  // Denormalise by 1-eb with the hidden bit restored; shifted-out bits feed sticky.
  assign sh   = 12'sd1 - s1_eb;
  assign wide = {1'b1, s1_m, s1_g, 25'd0} >> sh[4:0];
  assign dm   = wide[49:26];
  assign dg   = wide[25];
  assign ds   = s1_sticky || (|wide[24:0]);
  assign dinc = dg && (ds || dm[0]);
  assign dr   = dm + {23'd0, dinc};
`endif

  always_comb begin
    nx_dst = 32'd0;
    nx_ovf = 1'b0;
    nx_unf = 1'b0;
    nx_inx = 1'b0;
    case (s1_cls)
      CLS_ZERO: nx_dst = {s1_sign, 31'd0};
      CLS_INF:  nx_dst = {s1_sign, 8'hFF, 23'd0};
      CLS_NAN:  nx_dst = {s1_sign, 8'hFF, 1'b1, s1_m[21:0]};
      default: begin
        if (s1_eb >= 12'sd255) begin
          nx_dst = {s1_sign, 8'hFF, 23'd0};
          nx_ovf = 1'b1;
          nx_inx = 1'b1;
        end else if (s1_eb >= 12'sd1) begin
          // Mantissa carry-out bumps the exponent and may reach infinity.
          if (exp9 == 9'd255) begin
            nx_dst = {s1_sign, 8'hFF, 23'd0};
            nx_ovf = 1'b1;
            nx_inx = 1'b1;
          end else begin
            nx_dst = {s1_sign, exp9[7:0], mr[22:0]};
            nx_inx = s1_g || s1_sticky;
          end
        end else begin
`ifdef FPU_F64TO32_DENORM_EN
          if (s1_eb < -12'sd24) begin
            nx_dst = {s1_sign, 31'd0};
            nx_unf = 1'b1;
            nx_inx = 1'b1;
          end else begin
            nx_dst = {s1_sign, 7'd0, dr[23], dr[22:0]};
            nx_inx = dg || ds;
            nx_unf = dg || ds;
          end
`else
          nx_dst = {s1_sign, 31'd0};
          nx_unf = 1'b1;
          nx_inx = 1'b1;
`endif
        end
      end
    endcase
  end

  // Flags are forced low whenever the stage holds a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_dst   <= 32'd0;
      s2_ovf   <= 1'b0;
      s2_unf   <= 1'b0;
      s2_inx   <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      s2_dst   <= nx_dst;
      s2_ovf   <= s1_valid && nx_ovf;
      s2_unf   <= s1_valid && nx_unf;
      s2_inx   <= s1_valid && nx_inx;
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.dst       = s2_dst;
  assign bus.flg_ovf   = s2_ovf;
  assign bus.flg_unf   = s2_unf;
  assign bus.flg_inx   = s2_inx;

endmodule

// File: tb/tb_fpu_fp64_to_fp32.sv
// Bench for fpu_fp64_to_fp32: directed vectors plus an arithmetic reference model
// scoreboarding every output cycle; honours FPU_F64TO32_DENORM_EN like the design.
module tb_fpu_fp64_to_fp32;

  logic clk;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   rcv = 0;
  logic [34:0] expQ[$];

  fpu_fp64_to_fp32_if bus();

  fpu_fp64_to_fp32 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Exact-arithmetic reference: value = {1,f} * 2^(te-52), rounded to the binary32 quantum.
  function automatic logic [34:0] model(input logic [63:0] v);
    logic        s;
    logic [10:0] e;
    logic [51:0] f;
    int          te, q, n, expf;
    logic [63:0] sig, r, rem, half;
    logic        inx, tiny;
    s = v[63];
    e = v[62:52];
    f = v[51:0];
    if (e == 11'd0) return {s, 31'd0, 3'b000};
    if (e == 11'h7FF) begin
      if (f == 52'd0) return {s, 8'hFF, 23'd0, 3'b000};
      return {s, 8'hFF, 1'b1, f[50:29], 3'b000};
    end
    te   = int'(e) - 1023;
    tiny = (te < -126);
`ifndef FPU_F64TO32_DENORM_EN
    if (tiny) return {s, 31'd0, 3'b011};
`endif
    q   = ((te < -126) ? -126 : te) - 23;
    n   = q - te + 52;
    sig = {11'd0, 1'b1, f};
    if (n >= 60) begin
      r   = 64'd0;
      inx = 1'b1;
    end else begin
      r    = sig >> n;
      rem  = sig - (r << n);
      half = 64'd1 << (n - 1);
      if (rem > half || (rem == half && r[0])) r = r + 64'd1;
      inx = (rem != 64'd0);
    end
    if (r == (64'd1 << 24)) begin
      r = 64'd1 << 23;
      q = q + 1;
    end
    expf = (r < (64'd1 << 23)) ? 0 : q + 150;
    if (expf >= 255) return {s, 8'hFF, 23'd0, 3'b101};
    return {s, 8'(expf), r[22:0], 1'b0, tiny && inx, inx};
  endfunction

  // Scoreboard: every non-reset cycle, compare what the DUT shows against the model queue.
  task automatic monitorLoop();
    forever begin
      @(negedge clk);
      if (reset) begin
        expQ.delete();
      end else begin
        if (bus.out_valid) begin
          if (expQ.size() == 0) begin
            checkVal("stray_out_valid", 64'(bus.out_valid), 64'd0);
          end else begin
            checkVal("stream_result", 64'({bus.dst, bus.flg_ovf, bus.flg_unf, bus.flg_inx}), 64'(expQ[0]));
            if (bus.out_ready) begin
              void'(expQ.pop_front());
              rcv++;
            end
          end
        end else begin
          checkVal("idle_flags", 64'({bus.flg_ovf, bus.flg_unf, bus.flg_inx}), 64'd0);
        end
        if (bus.in_valid && bus.in_ready) expQ.push_back(model(bus.src));
      end
    end
  endtask

  task automatic applyStimulus(input logic [63:0] v);
    logic ok;
    ok = 1'b0;
    bus.src      = v;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) checkVal("accept_timeout", 64'(ok), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] expDst, input logic [2:0] expFlg);
    int lat;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) begin
      checkVal({name, "_timeout"}, 64'(bus.out_valid), 64'd1);
    end else begin
      checkVal({name, "_latency"}, 64'(lat), 64'd2);
      checkVal(name, 64'({bus.dst, bus.flg_ovf, bus.flg_unf, bus.flg_inx}), 64'({expDst, expFlg}));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runVec(input string name, input logic [63:0] v, input logic [31:0] expDst, input logic [2:0] expFlg);
    applyStimulus(v);
    checkOutput(name, expDst, expFlg);
  endtask

  initial begin
    int rcv0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.src       = 64'd0;
    bus.out_ready = 1'b1;
    fork
      monitorLoop();
    join_none
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    checkVal("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkVal("reset_dst", 64'(bus.dst), 64'd0);
    checkVal("reset_flags", 64'({bus.flg_ovf, bus.flg_unf, bus.flg_inx}), 64'd0);
    checkVal("reset_in_ready", 64'(bus.in_ready), 64'd1);

    // Hand-computed pins on the reference model itself.
    checkVal("model_one", 64'(model(64'h3FF0000000000000)), 64'({32'h3F800000, 3'b000}));
    checkVal("model_tie_odd", 64'(model(64'h3FF0000030000000)), 64'({32'h3F800002, 3'b001}));
    checkVal("model_ovf", 64'(model(64'h47F0000000000000)), 64'({32'h7F800000, 3'b101}));
    checkVal("model_tiny", 64'(model(64'h3690000000000000)), 64'({32'h00000000, 3'b011}));
`ifdef FPU_F64TO32_DENORM_EN
    checkVal("model_denorm", 64'(model(64'h3800000000000000)), 64'({32'h00400000, 3'b000}));
`else
    checkVal("model_denorm", 64'(model(64'h3800000000000000)), 64'({32'h00000000, 3'b011}));
`endif

    runVec("one",          64'h3FF0000000000000, 32'h3F800000, 3'b000);
    runVec("tie_even",     64'h3FF0000010000000, 32'h3F800000, 3'b001);
    runVec("tie_odd",      64'h3FF0000030000000, 32'h3F800002, 3'b001);
    runVec("neg_1p5",      64'hBFF8000000000000, 32'hBFC00000, 3'b000);
    runVec("carry_to_2",   64'h3FFFFFFFF0000000, 32'h40000000, 3'b001);
    runVec("ovf_big",      64'h47F0000000000000, 32'h7F800000, 3'b101);
    runVec("ovf_round",    64'h47EFFFFFF0000000, 32'h7F800000, 3'b101);
    runVec("neg_inf",      64'hFFF0000000000000, 32'hFF800000, 3'b000);
    runVec("qnan",         64'h7FF4000000000000, 32'h7FE00000, 3'b000);
    runVec("dbl_denorm",   64'h0000000000000001, 32'h00000000, 3'b000);
    runVec("min_normal",   64'h3810000000000000, 32'h00800000, 3'b000);
    runVec("tiny_2m150",   64'h3690000000000000, 32'h00000000, 3'b011);
`ifdef FPU_F64TO32_DENORM_EN
    runVec("half_min",     64'h3800000000000000, 32'h00400000, 3'b000);
    runVec("round_to_min", 64'h380FFFFFFFFFFFFF, 32'h00800000, 3'b011);
`else
    runVec("half_min",     64'h3800000000000000, 32'h00000000, 3'b011);
    runVec("round_to_min", 64'h380FFFFFFFFFFFFF, 32'h00000000, 3'b011);
`endif

    // Backpressure: five back-to-back operands with a four-cycle consumer stall.
    rcv0 = rcv;
    fork
      begin
        applyStimulus(64'h4000000000000000);
        applyStimulus(64'hC008000000000000);
        applyStimulus(64'h3FF0000030000000);
        applyStimulus(64'h47F0000000000000);
        applyStimulus(64'h3FD5555555555555);
      end
      begin
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (2) begin
          @(posedge clk);
          #1;
        end
        checkVal("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        checkVal("bp_out_valid_held", 64'(bus.out_valid), 64'd1);
        repeat (2) begin
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 30 && rcv < rcv0 + 5; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    checkVal("bp_result_count", 64'(rcv - rcv0), 64'd5);
    checkVal("bp_queue_empty", 64'(expQ.size()), 64'd0);

    // Reset with both stages occupied discards everything in flight.
    bus.out_ready = 1'b0;
    applyStimulus(64'h3FF0000000000000);
    applyStimulus(64'h4000000000000000);
    checkVal("rst_pipe_full", 64'(bus.in_ready), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkVal("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkVal("rst_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    runVec("post_reset", 64'hBFF0000000000000, 32'hBF800000, 3'b000);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
